// File: rtl/keycode_event_bank.sv
`default_nettype none
// ============================================================================
// Module   : keycode_event_bank
// Brief    : NUM_KEYS host-written keycode slots, commit-time press/release
//            diff scan, and a first-word-fall-through event FIFO.
//            Optional macro KEYCODE_ROLLOVER_FILTER_EN drops commits that
//            carry HID ErrorRollOver (0x01).
// Revision : 1.0 - initial release
// ============================================================================
module keycode_event_bank #(
  parameter int NUM_KEYS   = 6,
  parameter int KEY_W      = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        wr_en,
  input  logic [$clog2(NUM_KEYS)-1:0] wr_slot,
  input  logic [KEY_W-1:0]            wr_data,
  input  logic                        commit,
  output logic                        busy,
  output logic [NUM_KEYS*KEY_W-1:0]   keycodes_out,
  output logic                        ev_valid,
  input  logic                        ev_ready,
  output logic [KEY_W-1:0]            ev_code,
  output logic                        ev_press,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  input  logic                        clear_ovf
);

  localparam int                 c_IDX_W    = $clog2(NUM_KEYS);
  localparam int                 c_PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [c_IDX_W:0]   c_NUM_KEYS = (c_IDX_W+1)'(NUM_KEYS);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_KEYS - 1);
  localparam logic [c_PTR_W:0]   c_DEPTH    = (c_PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SCAN_REL = 2'd1,
    ST_SCAN_PRS = 2'd2
  } state_t;

  logic [KEY_W-1:0]   r_shadow [NUM_KEYS];
  logic [KEY_W-1:0]   r_active [NUM_KEYS];
  logic [KEY_W-1:0]   r_prev   [NUM_KEYS];
  state_t             r_state, w_state_nxt;
  logic [c_IDX_W-1:0] r_idx, w_idx_nxt;
  logic [KEY_W:0]     r_mem    [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic               r_overflow;

  logic               w_rollover, w_commit_ok;
  logic               w_scan_rel, w_in_other, w_dup;
  logic [KEY_W-1:0]   w_cand;
  logic               w_push, w_pop, w_push_ok, w_drop;

`ifdef KEYCODE_ROLLOVER_FILTER_EN
  always_comb begin
    w_rollover = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (r_shadow[i] == KEY_W'(1)) w_rollover = 1'b1;
  end
`else
  assign w_rollover = 1'b0;
`endif

  assign w_commit_ok = commit && (r_state == ST_IDLE) && !w_rollover;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
        r_prev[i]   <= '0;
      end
    end else begin
      if (wr_en && ({1'b0, wr_slot} < c_NUM_KEYS)) r_shadow[wr_slot] <= wr_data;
      if (w_commit_ok) begin
        r_prev   <= r_active;
        r_active <= r_shadow;
      end
    end
  end

  // Candidate is the scanned slot; it must be absent from the other set and
  // be its first occurrence within its own set.
  always_comb begin
    w_scan_rel = (r_state == ST_SCAN_REL);
    w_cand     = w_scan_rel ? r_prev[r_idx] : r_active[r_idx];
    w_in_other = 1'b0;
    w_dup      = 1'b0;
    for (int j = 0; j < NUM_KEYS; j++) begin
      if ((w_scan_rel ? r_active[j] : r_prev[j]) == w_cand) w_in_other = 1'b1;
      if ((j < int'(r_idx)) && ((w_scan_rel ? r_prev[j] : r_active[j]) == w_cand))
        w_dup = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_push      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_commit_ok) begin
          w_state_nxt = ST_SCAN_REL;
          w_idx_nxt   = '0;
        end
      end
      ST_SCAN_REL, ST_SCAN_PRS: begin
        w_push = (w_cand != '0) && !w_in_other && !w_dup;
        if (r_idx == c_LAST_IDX) begin
          w_idx_nxt   = '0;
          w_state_nxt = (r_state == ST_SCAN_REL) ? ST_SCAN_PRS : ST_IDLE;
        end else begin
          w_idx_nxt = r_idx + c_IDX_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
  assign w_pop     = (r_count != '0) && ev_ready;
  assign w_push_ok = w_push && ((r_count != c_DEPTH) || w_pop);
  assign w_drop    = w_push && !w_push_ok;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= {w_cand, !w_scan_rel};
        r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop)         r_overflow <= 1'b1;
      else if (clear_ovf) r_overflow <= 1'b0;
    end
  end

  generate
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_pack
      assign keycodes_out[k*KEY_W +: KEY_W] = r_active[k];
    end
  endgenerate

  assign busy       = (r_state != ST_IDLE);
  assign ev_valid   = (r_count != '0);
  assign ev_code    = ev_valid ? r_mem[r_rd_ptr][KEY_W:1] : '0;
  assign ev_press   = ev_valid ? r_mem[r_rd_ptr][0] : 1'b0;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire
